// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - MEM-stage request/response and data-memory bus bundle for the load/store unit
//
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : MEM-stage request handshake
//   rsp_valid/rsp_rdata/rsp_err                              : one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata                 : memory request, held until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata                             : memory grant and read return
// Modports:
//   master : the load/store unit (drives rsp_* and mem_* requests)
//   slave  : the surrounding MEM stage plus data memory
interface load_store_unit_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator for RISC-V style LB/LH/LW/LBU/LHU/SB/SH/SW
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : load_store_unit_if.master (MEM-stage request/response, memory request/grant/read)
// Build option:
//   MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses answer with rsp_err
//                      and never reach memory; otherwise the low address bits are ignored.
module load_store_unit #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                reset,
    load_store_unit_if.master   bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

    state_t      state;
    logic [TW-1:0] timer;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;

    logic              illegal;
    logic              misaligned;
    logic [3:0]        be_n;
    logic [DATA_W-1:0] wdata_n;

    // Stores have no unsigned forms, so any funct3 with bit 2 set is illegal for we=1.
    assign illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                     (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << bus.req_addr[1:0];
                wdata_n = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_n    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = bus.req_wdata;
            end
        endcase
    end

    // funct3[2] selects zero-extension for LBU/LHU.
    function automatic logic [DATA_W-1:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                                  input logic [DATA_W-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   extract = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   extract = {{16{h[15] & ~f3[2]}}, h};
            default: extract = w;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            we_q          <= 1'b0;
            f3_q          <= 3'b000;
            lane_q        <= 2'b00;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= 4'b0000;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Stray gnt/rvalid from an abandoned access land here and are ignored.
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        f3_q          <= bus.req_funct3;
                        lane_q        <= bus.req_addr[1:0];
                        timer         <= '0;
                        bus.req_ready <= 1'b0;
                        if (illegal || misaligned) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end else begin
                            state         <= ISSUE;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.req_we;
                            bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            bus.mem_be    <= be_n;
                            bus.mem_wdata <= wdata_n;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_gnt || timer == TIMER_LAST) begin
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_be    <= 4'b0000;
                        bus.mem_wdata <= '0;
                        timer         <= '0;
                        if (bus.mem_gnt && !we_q) begin
                            state <= WAIT_R;
                        end else begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= !bus.mem_gnt;
                            bus.rsp_rdata <= '0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_R: begin
                    if (bus.mem_rvalid) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= extract(f3_q, lane_q, bus.mem_rdata);
                    end else if (timer == TIMER_LAST) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
